// File: rtl/seg_instruction_fetch_pkg.sv
// Shared definitions for the segmented instruction-fetch stage:
// controller states and the two special instruction words.
package seg_instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

endpackage

// File: rtl/seg_instruction_fetch_instruction_memory.sv
// Instruction store: synchronous write port for program loading,
// asynchronous read port so the fetched word is available in the same cycle.
module instruction_memory
    import seg_instruction_fetch_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int NB_ADDR_MEM = 10
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [NB_ADDR_MEM-1:0] i_waddr,
    input  logic [LEN-1:0]         i_wdata,
    input  logic [NB_ADDR_MEM-1:0] i_raddr,
    output logic [LEN-1:0]         o_rdata
);

    // No reset: the program must survive a core reset.
    logic [LEN-1:0] mem [1 << NB_ADDR_MEM];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/seg_instruction_fetch.sv
// Instruction-fetch stage with LOAD/RUN/HALT control, producing the IF/ID
// register (instruction and PC+1) under branch, stall and jump control.
module seg_instruction_fetch
    import seg_instruction_fetch_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int NB_ADDR_MEM = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_prog_we,
    input  logic [NB_ADDR_MEM-1:0] i_prog_addr,
    input  logic [LEN-1:0]         i_prog_data,
    input  logic                   i_stall_flag,
    input  logic                   i_jump_flag,
    input  logic [LEN-1:0]         i_PC_dir_jump,
    input  logic                   i_branch_flag,
    input  logic [LEN-1:0]         i_PC_branch,
    output logic [LEN-1:0]         o_PC,
    output logic [LEN-1:0]         o_instruction,
    output logic [LEN-1:0]         o_pc_current,
    output logic                   o_halt
);

    fetch_state_e   state_q, state_d;
    logic [LEN-1:0] pc_q, pc_d;
    logic [LEN-1:0] opc_q, opc_d;
    logic [LEN-1:0] instr_q, instr_d;
    logic [LEN-1:0] fetched;
    logic [LEN-1:0] pc_inc;
    logic           mem_we;

    // Program writes are only honoured while loading.
    assign mem_we = i_prog_we && (state_q == ST_LOAD);
    assign pc_inc = pc_q + LEN'(1);

    instruction_memory #(
        .LEN        (LEN),
        .NB_ADDR_MEM(NB_ADDR_MEM)
    ) u_imem (
        .i_clk  (i_clk),
        .i_we   (mem_we),
        .i_waddr(i_prog_addr),
        .i_wdata(i_prog_data),
        .i_raddr(pc_q[NB_ADDR_MEM-1:0]),
        .o_rdata(fetched)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        case (state_q)
            ST_LOAD: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Branch beats stall beats jump beats halt detection.
                if (i_branch_flag) begin
                    pc_d    = i_PC_branch;
                    opc_d   = '0;
                    instr_d = LEN'(NOP_WORD);
                end else if (i_stall_flag) begin
                    pc_d = pc_q;
                end else if (i_jump_flag) begin
                    pc_d    = i_PC_dir_jump;
                    opc_d   = '0;
                    instr_d = LEN'(NOP_WORD);
                end else if (fetched == LEN'(HALT_OPCODE)) begin
                    state_d = ST_HALT;
                    opc_d   = '0;
                    instr_d = LEN'(NOP_WORD);
                end else begin
                    pc_d    = pc_inc;
                    opc_d   = pc_inc;
                    instr_d = fetched;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
            opc_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            instr_q <= instr_d;
        end
    end

    assign o_PC          = opc_q;
    assign o_instruction = instr_q;
    assign o_pc_current  = pc_q;
    assign o_halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Directed plus randomized bench for seg_instruction_fetch, checked every cycle
// against a cycle-level behavioural model of the fetch stage.
module tb_seg_instruction_fetch;

    localparam int LEN    = 32;
    localparam int NB     = 10;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_start;
    logic            i_prog_we;
    logic [NB-1:0]   i_prog_addr;
    logic [LEN-1:0]  i_prog_data;
    logic            i_stall_flag;
    logic            i_jump_flag;
    logic [LEN-1:0]  i_PC_dir_jump;
    logic            i_branch_flag;
    logic [LEN-1:0]  i_PC_branch;
    logic [LEN-1:0]  o_PC;
    logic [LEN-1:0]  o_instruction;
    logic [LEN-1:0]  o_pc_current;
    logic            o_halt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [1024];
    logic [31:0] m_pc, m_opc, m_instr;
    int          m_state;

    seg_instruction_fetch #(.LEN(LEN), .NB_ADDR_MEM(NB)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_prog_we    (i_prog_we),
        .i_prog_addr  (i_prog_addr),
        .i_prog_data  (i_prog_data),
        .i_stall_flag (i_stall_flag),
        .i_jump_flag  (i_jump_flag),
        .i_PC_dir_jump(i_PC_dir_jump),
        .i_branch_flag(i_branch_flag),
        .i_PC_branch  (i_PC_branch),
        .o_PC         (o_PC),
        .o_instruction(o_instruction),
        .o_pc_current (o_pc_current),
        .o_halt       (o_halt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the fetch stage as described behaviourally.
    task automatic model_edge();
        logic [31:0] word;
        if (!i_rst) begin
            m_pc = 0; m_opc = 0; m_instr = 0; m_state = M_LOAD;
        end else if (m_state == M_LOAD) begin
            if (i_prog_we) m_mem[i_prog_addr] = i_prog_data;
            if (i_start) m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            word = m_mem[m_pc[9:0]];
            if (i_branch_flag) begin
                m_pc = i_PC_branch; m_instr = 0; m_opc = 0;
            end else if (!i_stall_flag) begin
                if (i_jump_flag) begin
                    m_pc = i_PC_dir_jump; m_instr = 0; m_opc = 0;
                end else if (word == 32'hFFFF_FFFF) begin
                    m_state = M_HALT; m_instr = 0; m_opc = 0;
                end else begin
                    m_instr = word;
                    m_pc    = m_pc + 32'd1;
                    m_opc   = m_pc;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
        chk("pc_current", o_pc_current, m_pc);
        chk("o_PC", o_PC, m_opc);
        chk("o_instruction", o_instruction, m_instr);
        chk("o_halt", {31'b0, o_halt}, {31'b0, (m_state == M_HALT)});
    endtask

    task automatic idle_inputs();
        i_start = 0; i_prog_we = 0; i_prog_addr = '0; i_prog_data = '0;
        i_stall_flag = 0; i_jump_flag = 0; i_PC_dir_jump = '0;
        i_branch_flag = 0; i_PC_branch = '0;
    endtask

    task automatic check_halt_trace(input string tag);
        i_start = 1; tick(); i_start = 0;
        tick();
        chk({tag, "_i0"}, o_instruction, 32'h2001_0005);
        chk({tag, "_pc0"}, o_PC, 32'd1);
        tick();
        chk({tag, "_i1"}, o_instruction, 32'h2002_0007);
        chk({tag, "_pc1"}, o_PC, 32'd2);
        tick();
        chk({tag, "_nop"}, o_instruction, 32'h0);
        chk({tag, "_halt"}, {31'b0, o_halt}, 32'd1);
        chk({tag, "_pchold"}, o_pc_current, 32'd2);
        $display("step %s: halted pc=%0d", tag, o_pc_current);
    endtask

    initial begin
        logic [31:0] d;
        m_pc = 0; m_opc = 0; m_instr = 0; m_state = M_LOAD;
        idle_inputs();

        // Reset state
        i_rst = 0; tick(); tick();
        chk("reset_pc", o_pc_current, 32'd0);
        chk("reset_instr", o_instruction, 32'd0);
        $display("step reset: pc=%0d halt=%0b", o_pc_current, o_halt);

        // Fill the whole memory so every fetch address is defined
        i_rst = 1; i_prog_we = 1;
        for (int a = 0; a < 1024; a++) begin
            d = $urandom;
            if (d == 32'hFFFF_FFFF) d = 32'h1;
            if (a == 0) d = 32'h2001_0005;
            if (a == 1) d = 32'h2002_0007;
            if (a == 2) d = 32'hFFFF_FFFF;
            i_prog_addr = NB'(a); i_prog_data = d;
            tick();
        end
        i_prog_we = 0;
        chk("load_holds_pc", o_pc_current, 32'd0);
        $display("step load: 1024 words written");

        check_halt_trace("run1");

        // Control inputs and writes while halted have no effect
        i_branch_flag = 1; i_PC_branch = 32'h10; i_jump_flag = 1; i_prog_we = 1;
        tick(); tick();
        chk("halt_ignores_ctl", o_pc_current, 32'd2);
        idle_inputs();

        // Reset from HALT, rerun reproduces the trace
        i_rst = 0; tick(); i_rst = 1;
        chk("rst_halt_clr", {31'b0, o_halt}, 32'd0);
        check_halt_trace("rerun");

        // Reprogram word 2 so the program keeps running
        i_rst = 0; tick(); i_rst = 1;
        i_prog_we = 1; i_prog_addr = NB'(2); i_prog_data = 32'h2003_0009; i_start = 1;
        tick();
        idle_inputs();
        tick(); tick();
        // Write attempt during RUN must be ignored
        i_prog_we = 1; i_prog_addr = '0; i_prog_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        tick();
        chk("at_pc4", o_pc_current, 32'd4);

        i_stall_flag = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_pc", o_pc_current, 32'd4);
            chk("stall_opc", o_PC, 32'd4);
            chk("stall_instr", o_instruction, m_mem[3]);
        end
        i_stall_flag = 0;
        tick();
        chk("resume_opc", o_PC, 32'd5);
        chk("resume_instr", o_instruction, m_mem[4]);
        $display("step stall: resumed pc=%0d", o_pc_current);

        i_jump_flag = 1; i_PC_dir_jump = 32'h40;
        tick();
        chk("jump_pc", o_pc_current, 32'h40);
        chk("jump_bubble", o_instruction, 32'h0);
        idle_inputs();
        tick();
        chk("jump_fetch", o_instruction, m_mem[32'h40]);
        chk("jump_opc", o_PC, 32'h41);
        $display("step jump: o_PC=%h", o_PC);

        i_branch_flag = 1; i_PC_branch = 32'h10;
        i_stall_flag = 1; i_jump_flag = 1; i_PC_dir_jump = 32'h80;
        tick();
        chk("branch_prio_pc", o_pc_current, 32'h10);
        chk("branch_bubble", o_instruction, 32'h0);
        idle_inputs();
        $display("step branch: pc=%h", o_pc_current);

        // mem[0] survived the RUN-time write attempt
        i_rst = 0; tick(); i_rst = 1;
        i_start = 1; tick(); i_start = 0;
        tick();
        chk("mem0_intact", o_instruction, 32'h2001_0005);
        $display("step we_in_run: mem0=%h", o_instruction);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            i_rst         = ($urandom_range(0, 63) != 0);
            i_start       = ($urandom_range(0, 3) == 0);
            i_prog_we     = $urandom_range(0, 1) == 1;
            i_prog_addr   = NB'($urandom);
            i_prog_data   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            i_stall_flag  = ($urandom_range(0, 4) == 0);
            i_jump_flag   = ($urandom_range(0, 5) == 0);
            i_branch_flag = ($urandom_range(0, 7) == 0);
            i_PC_dir_jump = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
            i_PC_branch   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
            tick();
        end
        idle_inputs();
        $display("step random: 400 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
